// File: rtl/debug_scratch_ctrl.sv
// Host command front end for the debug data RAM scratch port.
// Set-address / write-byte / burst-read with an auto-incrementing byte pointer.
module debug_scratch_ctrl #(
  parameter int INDEX  = 8,
  parameter int LANE_W = 3,
  parameter int ADDR_W = INDEX + LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [15:0]       cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [7:0]        rsp_data_o,
  output logic [ADDR_W-1:0] scratchAddr_o,
  output logic [7:0]        scratchWrData_o,
  output logic              scratchWrEn_o,
  input  logic [7:0]        scratchRdData_i,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_RESP
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_nxt;
  logic [LANE_W-1:0]   lane;
  logic [INDEX-1:0]    idx;
  logic [7:0]          cnt;
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                rsp_valid;
  logic [7:0]          rsp_data;
  logic                err;
  logic                accept;
  logic                op_set;
  logic                op_wr;
  logic                op_rd;
  logic                op_rsv;
  logic                unused_bits;

  assign lane = ptr[ADDR_W-1:INDEX];
  assign idx  = ptr[INDEX-1:0];

  // Lane is the low-order byte counter; it carries into the word index.
  always_comb begin
    ptr_nxt = {lane + LANE_W'(1), idx};
    if (&lane)
      ptr_nxt = {LANE_W'(0), idx + INDEX'(1)};
  end

  assign op_set = (cmd_op_i == 2'd0);
  assign op_wr  = (cmd_op_i == 2'd1);
  assign op_rd  = (cmd_op_i == 2'd2);
  assign op_rsv = (cmd_op_i == 2'd3);

  assign cmd_ready_o = (state == IDLE) && !reset;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign unused_bits = ^cmd_data_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              op_set: ptr <= cmd_data_i[ADDR_W-1:0];
              op_wr: begin
                wr_data <= cmd_data_i[7:0];
                wr_en   <= 1'b1;
                state   <= WR;
              end
              op_rd: begin
                cnt   <= cmd_data_i[7:0];
                state <= RD_ISSUE;
              end
              op_rsv: err <= 1'b1;
            endcase
          end
        end
        WR: begin
          wr_en <= 1'b0;
          ptr   <= ptr_nxt;
          state <= IDLE;
        end
        RD_ISSUE: begin
          rsp_data  <= scratchRdData_i;
          rsp_valid <= 1'b1;
          state     <= RD_RESP;
        end
        RD_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_nxt;
            if (cnt == 8'd0) begin
              state <= IDLE;
            end else begin
              cnt   <= cnt - 8'd1;
              state <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign scratchAddr_o   = ptr;
  assign scratchWrData_o = wr_data;
  assign scratchWrEn_o   = wr_en;
  assign rsp_valid_o     = rsp_valid;
  assign rsp_data_o      = rsp_data;
  assign busy_o          = (state != IDLE);
  assign err_o           = err;

endmodule

// File: tb/tb_debug_scratch_ctrl.sv
// Directed bench for debug_scratch_ctrl with a byte-addressed model RAM.
// Expected values are hand-computed from the command sequence.
module tb_debug_scratch_ctrl;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [15:0]   cmd_data_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [7:0]    rsp_data_o;
  logic [AW-1:0] scratchAddr_o;
  logic [7:0]    scratchWrData_o;
  logic          scratchWrEn_o;
  logic [7:0]    scratchRdData_i;
  logic          busy_o;
  logic          err_o;

  logic [7:0] mem [2**AW];
  int n_chk = 0;
  int n_err = 0;
  int wr_pulses = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  debug_scratch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i),
    .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o),
    .scratchAddr_o(scratchAddr_o),
    .scratchWrData_o(scratchWrData_o),
    .scratchWrEn_o(scratchWrEn_o),
    .scratchRdData_i(scratchRdData_i),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  assign scratchRdData_i = mem[scratchAddr_o];

  always @(posedge clk) begin
    if (scratchWrEn_o) begin
      mem[scratchAddr_o] <= scratchWrData_o;
      wr_pulses <= wr_pulses + 1;
    end
  end

  always @(negedge clk)
    if (scratchWrEn_o && rsp_valid_o) overlap <= overlap + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [1:0] op, input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_op_i = op;
    cmd_data_i = d;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 0);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  // Entered at posedge+1 of acceptance or previous handshake.
  task automatic rd_byte(input string tag, input logic [7:0] exp,
                         input logic [AW-1:0] exp_addr);
    int lat;
    lat = 1;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    while (!rsp_valid_o && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 2);
    chk({tag, "_data"}, rsp_data_o, exp);
    chk({tag, "_addr"}, scratchAddr_o, exp_addr);
    chk({tag, "_busy"}, busy_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_word5;
    for (int l = 0; l < 8; l++)
      mem[{3'(l), 8'd5}] = 8'((l + 1) * 8'h11);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 8'h00;
    mem[11'h7FF] = 8'hC3;
    mem[11'h000] = 8'h3C;
    reset = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i = 2'd0;
    cmd_data_i = 16'h0;
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1;
    cmd_op_i = 2'd3;
    @(negedge clk);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", scratchAddr_o, 0);
    chk("rst_wren", scratchWrEn_o, 0);
    chk("rst_wdata", scratchWrData_o, 0);
    chk("rst_rvalid", rsp_valid_o, 0);
    chk("rst_rdata", rsp_data_o, 0);
    @(posedge clk); #1;
    chk("rst_err", err_o, 0);
    cmd_valid_i = 1'b0;
    reset = 1'b0;

    // single write, lane increment
    send(2'd0, 16'h005);
    chk("set_addr", scratchAddr_o, 11'h005);
    chk("set_busy", busy_o, 0);
    send(2'd1, 16'h00A5);
    @(negedge clk);
    chk("wr1_en", scratchWrEn_o, 1);
    chk("wr1_addr", scratchAddr_o, 11'h005);
    chk("wr1_data", scratchWrData_o, 8'hA5);
    chk("wr1_busy", busy_o, 1);
    chk("wr1_ready", cmd_ready_o, 0);
    @(posedge clk); #1;
    chk("wr1_en_off", scratchWrEn_o, 0);
    chk("wr1_ptr", scratchAddr_o, 11'h105);
    chk("wr1_mem", mem[11'h005], 8'hA5);
    chk("wr1_pulses", 64'(wr_pulses), 1);

    // lane wrap into next index
    send(2'd0, 16'h705);
    send(2'd1, 16'h0011);
    @(negedge clk);
    chk("wr2_addr", scratchAddr_o, 11'h705);
    send(2'd1, 16'h0022);
    @(negedge clk);
    chk("wr3_addr", scratchAddr_o, 11'h006);
    @(posedge clk); #1;
    chk("wr2_mem", mem[11'h705], 8'h11);
    chk("wr3_mem", mem[11'h006], 8'h22);
    chk("wr_pulses", 64'(wr_pulses), 3);

    // 8-byte burst over word 5
    load_word5();
    send(2'd0, 16'h005);
    send(2'd2, 16'h0007);
    for (int l = 0; l < 8; l++)
      rd_byte($sformatf("burst%0d", l), 8'((l + 1) * 8'h11), {3'(l), 8'd5});
    chk("burst_busy_end", busy_o, 0);
    chk("burst_ready_end", cmd_ready_o, 1);
    chk("burst_ptr_end", scratchAddr_o, 11'h006);

    // back-pressure: host stalls 5 cycles on first byte
    rsp_ready_i = 1'b0;
    send(2'd0, 16'h005);
    send(2'd2, 16'h0003);
    @(negedge clk);
    @(negedge clk);
    chk("stall_valid0", rsp_valid_o, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid_o, 1);
      chk("stall_data", rsp_data_o, 8'h11);
      chk("stall_ptr", scratchAddr_o, 11'h005);
      chk("stall_ready", cmd_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rd_byte("stall_b1", 8'h22, 11'h105);
    rd_byte("stall_b2", 8'h33, 11'h205);
    rd_byte("stall_b3", 8'h44, 11'h305);
    chk("stall_busy_end", busy_o, 0);

    // wrap across top of address space
    send(2'd0, 16'h7FF);
    send(2'd2, 16'h0001);
    rd_byte("wrap0", 8'hC3, 11'h7FF);
    rd_byte("wrap1", 8'h3C, 11'h000);
    chk("wrap_ptr", scratchAddr_o, 11'h100);

    // reset with third byte pending
    send(2'd0, 16'h005);
    send(2'd2, 16'h0007);
    rd_byte("rb0", 8'h11, 11'h005);
    rd_byte("rb1", 8'h22, 11'h105);
    rsp_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rb2_pending", rsp_valid_o, 1);
    chk("rb2_data", rsp_data_o, 8'h33);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rb_rvalid", rsp_valid_o, 0);
    chk("rb_busy", busy_o, 0);
    chk("rb_ptr", scratchAddr_o, 0);
    chk("rb_rdata", rsp_data_o, 0);
    chk("rb_ready", cmd_ready_o, 1);

    // sticky error flag
    rsp_ready_i = 1'b1;
    send(2'd3, 16'h0123);
    chk("err_set", err_o, 1);
    chk("err_busy", busy_o, 0);
    chk("err_ptr", scratchAddr_o, 0);
    send(2'd0, 16'h123);
    chk("err_hold", err_o, 1);
    chk("err_setaddr", scratchAddr_o, 11'h123);
    repeat (3) @(posedge clk);
    #1;
    chk("err_hold2", err_o, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("err_clr", err_o, 0);

    chk("no_stray_wr", 64'(wr_pulses), 3);
    chk("wren_rsp_excl", 64'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
